// File: rtl/pwm_pkg.sv
// Shared types and default constants for the dead-time PWM generator.
// Holds the FSM state encoding and the reset-time default widths.
package pwm_pkg;

    localparam int         PWM_CNT_W  = 11;
    localparam logic [7:0] PWM_DT_DEF = 8'h40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/pwm_shadow_clamp.sv
// Period-boundary shadow registers for dead time, blanking length and clamped duty.
// Latency: one clock from load to shadow outputs; no backpressure (load is a strobe).
module pwm_shadow_clamp
    import pwm_pkg::*;
#(
    parameter int CNT_W   = PWM_CNT_W,
    parameter int DT_W    = $bits(PWM_DT_DEF),
    parameter int BLANK_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [CNT_W-1:0]   duty,
    input  logic [DT_W-1:0]    deadtime,
    input  logic [BLANK_W-1:0] blank_len,
    output logic [DT_W-1:0]    dt_sh,
    output logic [CNT_W-1:0]   duty_eff,
    output logic [BLANK_W-1:0] blank_sh,
    output logic               duty_clip
);

    localparam logic [CNT_W:0] MAX_X = {1'b0, {CNT_W{1'b1}}};

    logic [DT_W-1:0]    dt_q,    dt_d;
    logic [CNT_W-1:0]   duty_q,  duty_d;
    logic [BLANK_W-1:0] blank_q, blank_d;
    logic               clip_q,  clip_d;

    logic [CNT_W:0] duty_x, dt_x, lo_x, hi_x, eff_x;

    // One spare bit keeps MAX-dt and the comparisons free of wrap.
    always_comb begin
        duty_x  = {1'b0, duty};
        dt_x    = {{(CNT_W+1-DT_W){1'b0}}, deadtime};
        lo_x    = (duty_x > dt_x) ? duty_x : dt_x;
        hi_x    = MAX_X - dt_x;
        eff_x   = (lo_x > hi_x) ? hi_x : lo_x;

        dt_d    = dt_q;
        duty_d  = duty_q;
        blank_d = blank_q;
        clip_d  = clip_q;
        if (load) begin
            dt_d    = deadtime;
            duty_d  = eff_x[CNT_W-1:0];
            blank_d = blank_len;
            clip_d  = (eff_x != duty_x);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dt_q    <= '0;
            duty_q  <= '0;
            blank_q <= '0;
            clip_q  <= 1'b0;
        end else begin
            dt_q    <= dt_d;
            duty_q  <= duty_d;
            blank_q <= blank_d;
            clip_q  <= clip_d;
        end
    end

    assign dt_sh     = dt_q;
    assign duty_eff  = duty_q;
    assign blank_sh  = blank_q;
    assign duty_clip = clip_q;

endmodule

// File: rtl/pwm_dt_gen.sv
// Complementary PWM pair with dead time, blanking, duty clamping and latched OC fault.
// Outputs are registered compares of the period counter (1 clock latency); no backpressure.
module pwm_dt_gen
    import pwm_pkg::*;
#(
    parameter int CNT_W   = PWM_CNT_W,
    parameter int DT_W    = $bits(PWM_DT_DEF),
    parameter int BLANK_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [CNT_W-1:0]   duty,
    input  logic [DT_W-1:0]    deadtime,
    input  logic [BLANK_W-1:0] blank_len,
    input  logic               ovr_trip,
    input  logic               clr_fault,
    output logic               PWM1,
    output logic               PWM2,
    output logic               PWM_synch,
    output logic               ovr_I_blank,
    output logic               fault,
    output logic               duty_clip
);

    localparam int             XW     = CNT_W + 2;
    localparam logic [XW-1:0]  MAX_X  = {2'b00, {CNT_W{1'b1}}};
    localparam logic [XW-1:0]  ONE_X  = {{(XW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MAX_C = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    pwm_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             pwm1_q,  pwm1_d;
    logic             pwm2_q,  pwm2_d;
    logic             blank_q, blank_d;
    logic             load;

    logic [DT_W-1:0]    dt_sh;
    logic [CNT_W-1:0]   duty_eff;
    logic [BLANK_W-1:0] blank_sh;

    pwm_shadow_clamp #(
        .CNT_W   (CNT_W),
        .DT_W    (DT_W),
        .BLANK_W (BLANK_W)
    ) u_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .duty      (duty),
        .deadtime  (deadtime),
        .blank_len (blank_len),
        .dt_sh     (dt_sh),
        .duty_eff  (duty_eff),
        .blank_sh  (blank_sh),
        .duty_clip (duty_clip)
    );

    logic [XW-1:0] c_x, dt_x, eff_x, bl_x, lo1_x, lo2_x, b1_hi_x, b2_hi_x;
    logic          in_p1, in_p2, in_b1, in_b2;

    // Compare window bounds in XW bits so eff+dt+blank never wraps.
    always_comb begin
        c_x     = {2'b00, cnt_q};
        dt_x    = {{(XW-DT_W){1'b0}}, dt_sh};
        eff_x   = {2'b00, duty_eff};
        bl_x    = {{(XW-BLANK_W){1'b0}}, blank_sh};
        lo1_x   = dt_x + ONE_X;
        lo2_x   = eff_x + dt_x + ONE_X;
        b1_hi_x = dt_x + bl_x;
        b2_hi_x = eff_x + dt_x + bl_x;
        in_p1   = (c_x >= lo1_x) && (c_x <= eff_x);
        in_p2   = (c_x >= lo2_x) && (c_x <= MAX_X);
        in_b1   = (eff_x > dt_x) && (c_x >= lo1_x) && (c_x <= b1_hi_x);
        in_b2   = (lo2_x <= MAX_X) && (c_x >= lo2_x) && (c_x <= b2_hi_x);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pwm1_d  = 1'b0;
        pwm2_d  = 1'b0;
        blank_d = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (ovr_trip && !blank_q) begin
                    state_d = FAULT;
                    cnt_d   = '0;
                end else if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + ONE_C;
                    load    = (cnt_q == MAX_C);
                    pwm1_d  = in_p1;
                    pwm2_d  = in_p2;
                    blank_d = in_b1 || in_b2;
                end
            end
            FAULT: begin
                cnt_d = '0;
                if (clr_fault) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pwm1_q  <= 1'b0;
            pwm2_q  <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pwm1_q  <= pwm1_d;
            pwm2_q  <= pwm2_d;
            blank_q <= blank_d;
        end
    end

    assign PWM1        = pwm1_q;
    assign PWM2        = pwm2_q;
    assign ovr_I_blank = blank_q;
    assign PWM_synch   = (state_q == RUN) && (cnt_q == '0);
    assign fault       = (state_q == FAULT);

endmodule
